counter_modn_param: RTL
=======================

// Module: counter_modn_param
// PURPOSE
//  Parametrised successor of the 4-bit 4-mode counter: WIDTH-bit up/down/step-down/load counter
//  with a run-time modulus (LIMIT), so Q always stays in 0..LIMIT and wraps cleanly.
//  Sits in the same slot as the existing counter, driven by the stimulus and checker modules;
//  RCO and LOAD keep their meaning so the existing checker extends without change to the port list.
// PARAMETERS
//  WIDTH  4  counter, D and LIMIT width in bits (>=2)
//  STEP   3  decrement applied in MODO=2'b10 (1 <= STEP <= 2**WIDTH-1)
// PORTS
//  CLK     in   1      clock, all state updates on rising edge
//  RESET   in   1      asynchronous, active-low reset
//  ENABLE  in   1      1 = apply MODO this edge; 0 = hold
//  MODO    in   2      00 up +1, 01 down -1, 10 down -STEP, 11 load D
//  D       in   WIDTH  load value for MODO=11
//  LIMIT   in   WIDTH  terminal value; count modulus M = LIMIT+1 (computed in WIDTH+1 bits)
//  Q       out  WIDTH  registered count
//  RCO     out  1      registered 1-cycle pulse, high with the Q value produced by a wrap
//  LOAD    out  1      registered 1-cycle pulse, high with the Q value produced by a load
// BEHAVIOUR
//  - RESET=0: Q=0, RCO=0, LOAD=0 immediately, no clock needed; release takes effect on next edge.
//  - ENABLE=0 at edge: Q holds, RCO<=0, LOAD<=0. MODO/D/LIMIT ignored.
//  - Single-cycle latency: Q, RCO, LOAD all update on the same edge; no pipeline.
//  - Let k = 1 (MODO 00/01) or STEP (MODO 10); all arithmetic in WIDTH+1 bits, no silent overflow.
//  - Out-of-range recovery (Q > LIMIT, e.g. LIMIT lowered at run time), counting modes only:
//      up -> Q<=0; down modes -> Q<=LIMIT; RCO<=0 in both. Takes priority over normal counting.
//  - MODO 00, Q<=LIMIT: Q==LIMIT -> Q<=0, RCO<=1; else Q<=Q+1, RCO<=0.
//  - MODO 01/10, Q<=LIMIT: Q>=k -> Q<=Q-k, RCO<=0;
//      Q<k and k<=M -> Q<=Q+M-k, RCO<=1 (modular wrap);
//      k>M (STEP exceeds modulus) -> Q<=0, RCO<=1.
//  - MODO 11: Q<=min(D,LIMIT), LOAD<=1, RCO<=0. D>LIMIT clamps to LIMIT.
//  - LOAD<=0 on every non-load edge; RCO and LOAD are never both 1.
//  - LIMIT=0: M=1, Q stays 0; every counting edge pulses RCO.
//  - LIMIT=2**WIDTH-1: plain binary wrap (15->0 up, 0->15 down for WIDTH=4).
//  - LIMIT/D sampled only at the edge; changes between edges have no effect.
//  - No combinational path from any input to Q, RCO or LOAD.
// TESTING
//  1 WIDTH=4, count up, LIMIT=15, Q=14 -> Q=15,RCO=0; then Q=0,RCO=1; then Q=1,RCO=0.
//  2 LIMIT=9, MODO=10, STEP=3, Q=1 -> Q=8 RCO=1; 5; 2; 9 RCO=1 (wrap each crossing).
//  3 LIMIT=9, MODO=11: D=12 -> Q=9 LOAD=1; D=5 -> Q=5 LOAD=1; next MODO=00 -> Q=6 LOAD=0.
//  4 Q=7, ENABLE=0 for 3 edges -> Q=7, RCO=0, LOAD=0 throughout; MODO=01 from Q=0, LIMIT=9 -> Q=9 RCO=1.
//  5 Q=12, LIMIT changed to 5, MODO=00 -> Q=0 RCO=0; LIMIT=1, STEP=3, MODO=10 -> Q=0 RCO=1 each edge.
//  6 RESET low mid-count (Q=6, between edges) -> Q=0,RCO=0,LOAD=0 at once; repeat case 1 with WIDTH=8 (254->255->0 RCO).

Source files
------------

// File: rtl/counter_modn_param.sv
// counter_modn_param
//   WIDTH-bit counter with a run-time modulus M = LIMIT+1. Q always stays in
//   0..LIMIT. It can count up by 1, down by 1, down by STEP, or load D
//   (clamped to LIMIT).
//
//   CLK     in   clock; all state updates on the rising edge
//   RESET   in   asynchronous active-low reset
//   ENABLE  in   1 = apply MODO on this edge, 0 = hold
//   MODO    in   00 up +1, 01 down -1, 10 down -STEP, 11 load D
//   D       in   load value
//   LIMIT   in   terminal count
//   Q       out  registered count
//   RCO     out  registered one-cycle pulse, high with a wrapped Q value
//   LOAD    out  registered one-cycle pulse, high with a loaded Q value
module counter_modn_param #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEP  = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] LIMIT,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             LOAD
);

  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             rco_q, rco_d;
  logic             load_q, load_d;

  logic [WIDTH:0] q_w, m_w, k_w, sub_w, gap_w;

  // All decrement arithmetic is done one bit wider, so the top bit is a borrow.
  assign q_w   = {1'b0, q_q};
  assign m_w   = {1'b0, LIMIT} + ONE_W;
  assign k_w   = (MODO == 2'b10) ? STEP_W : ONE_W;
  assign sub_w = q_w - k_w;  // sub_w[WIDTH] set when Q < k
  assign gap_w = m_w - k_w;  // gap_w[WIDTH] set when k > M

  always_comb begin
    q_d    = q_q;
    rco_d  = 1'b0;
    load_d = 1'b0;
    if (ENABLE) begin
      unique case (MODO)
        2'b11: begin
          q_d    = (D > LIMIT) ? LIMIT : D;
          load_d = 1'b1;
        end
        2'b00: begin
          if (q_q > LIMIT) begin
            q_d = '0;
          end else if (q_q == LIMIT) begin
            q_d   = '0;
            rco_d = 1'b1;
          end else begin
            q_d = q_q + WIDTH'(1);
          end
        end
        default: begin
          if (q_q > LIMIT) begin
            q_d = LIMIT;
          end else if (!sub_w[WIDTH]) begin
            q_d = sub_w[WIDTH-1:0];
          end else if (!gap_w[WIDTH]) begin
            // Q < k <= M: Q + (M - k) < M, so the result always fits in WIDTH bits.
            q_d   = q_q + gap_w[WIDTH-1:0];
            rco_d = 1'b1;
          end else begin
            q_d   = '0;
            rco_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      q_q    <= '0;
      rco_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rco_q  <= rco_d;
      load_q <= load_d;
    end
  end

  assign Q    = q_q;
  assign RCO  = rco_q;
  assign LOAD = load_q;

endmodule
